// File: rtl/hex_scroller_pkg.sv
// Shared character codes, segment patterns and width helper for the hex_scroller slice.
// Segment vectors are active low, ordered {a,b,c,d,e,f,g}.
package hex_scroller_pkg;

    localparam logic [2:0] CH_H     = 3'b000;
    localparam logic [2:0] CH_E     = 3'b001;
    localparam logic [2:0] CH_L     = 3'b010;
    localparam logic [2:0] CH_O     = 3'b011;
    localparam logic [2:0] CH_BLANK = 3'b111;

    localparam logic [6:0] SEG_H     = 7'b1001000;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_O     = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index width that never collapses to zero bits for single-entry structures.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_char_dec.sv
// Combinational character-code to active-low seven-segment decoder.
// Codes wider than 3 bits with any upper bit set decode as blank.
module seg7_char_dec
    import hex_scroller_pkg::*;
#(
    parameter int CHAR_W = 3
) (
    input  logic [CHAR_W-1:0] code,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CHAR_W'(CH_H): seg = SEG_H;
            CHAR_W'(CH_E): seg = SEG_E;
            CHAR_W'(CH_L): seg = SEG_L;
            CHAR_W'(CH_O): seg = SEG_O;
            default:       seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroller.sv
// Scrolls a run-time writable message of character codes across NUM_DIGITS seven-segment digits.
// Optional blink gating is compiled in with `define HEX_SCROLLER_BLINK_EN (adds the blink input).
module hex_scroller
    import hex_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_LEN    = 8,
    parameter int CHAR_W     = 3,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run,
    input  logic                             dir,
    input  logic                             step,
`ifdef HEX_SCROLLER_BLINK_EN
    input  logic                             blink,
`endif
    input  logic                             wr_en,
    input  logic [clog2_min1(MSG_LEN)-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]                wr_data,
    output logic [7*NUM_DIGITS-1:0]          hex,
    output logic [clog2_min1(MSG_LEN)-1:0]   offset,
    output logic                             tick
);

    localparam int AW = clog2_min1(MSG_LEN);
    localparam int DW = clog2_min1(TICK_DIV);

    logic [DW-1:0]           div_cnt;
    logic [AW-1:0]           offset_q;
    logic [AW-1:0]           offset_nxt;
    logic                    adv;
    logic                    blank_now;
    logic [CHAR_W-1:0]       msg [MSG_LEN];
    logic [7*NUM_DIGITS-1:0] seg_flat;
    logic [7*NUM_DIGITS-1:0] hex_q;

    function automatic logic [CHAR_W-1:0] init_char(input int i);
        case (i)
            0:       return CHAR_W'(CH_H);
            1:       return CHAR_W'(CH_E);
            2, 3:    return CHAR_W'(CH_L);
            4:       return CHAR_W'(CH_O);
            default: return '1;
        endcase
    endfunction

    assign tick = (div_cnt == DW'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    assign adv = run ? tick : step;

    always_comb begin
        offset_nxt = offset_q;
        if (adv && (MSG_LEN > 1)) begin
            if (!dir) offset_nxt = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + AW'(1);
            else      offset_nxt = (offset_q == '0) ? AW'(MSG_LEN - 1) : offset_q - AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) offset_q <= '0;
        else        offset_q <= offset_nxt;
    end

    assign offset = offset_q;

    // NOTE: the buffer is a register file, not RAM, so it can carry the HELLO reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= init_char(i);
        end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
            msg[wr_addr] <= wr_data;
        end
    end

    // Each digit's distance from the window start is folded mod MSG_LEN at elaboration,
    // so at run time a single conditional subtract wraps the index.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int CDIST = (NUM_DIGITS - 1 - k) % MSG_LEN;
        logic [AW:0]   sum;
        logic [AW-1:0] idx;

        assign sum = {1'b0, offset_q} + (AW+1)'(CDIST);
        assign idx = (sum >= (AW+1)'(MSG_LEN)) ? AW'(sum - (AW+1)'(MSG_LEN)) : sum[AW-1:0];

        seg7_char_dec #(.CHAR_W(CHAR_W)) u_dec (
            .code (msg[idx]),
            .seg  (seg_flat[7*k +: 7])
        );
    end

`ifdef HEX_SCROLLER_BLINK_EN
    logic phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    phase <= 1'b0;
        else if (tick) phase <= ~phase;
    end

    assign blank_now = blink & phase;
`else
    assign blank_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         hex_q <= '1;
        else if (blank_now) hex_q <= '1;
        else                hex_q <= seg_flat;
    end

    assign hex = hex_q;

endmodule

// File: tb/tb_hex_scroller.sv
// Directed self-checking bench for hex_scroller (TICK_DIV=4, 8 digits, 8- and 6-entry messages).
module tb_hex_scroller;

    localparam logic [6:0] S_H = 7'b1001000;
    localparam logic [6:0] S_E = 7'b0110000;
    localparam logic [6:0] S_L = 7'b1110001;
    localparam logic [6:0] S_O = 7'b0000001;
    localparam logic [6:0] S_B = 7'b1111111;

    localparam logic [55:0] W_HELLO = {S_H, S_E, S_L, S_L, S_O, S_B, S_B, S_B};
    localparam logic [55:0] W_OFF1  = {S_E, S_L, S_L, S_O, S_B, S_B, S_B, S_H};
    localparam logic [55:0] W_OFF7  = {S_B, S_H, S_E, S_L, S_L, S_O, S_B, S_B};
    localparam logic [55:0] W_WR1   = {S_E, S_L, S_L, S_O, S_O, S_B, S_B, S_H};
    localparam logic [55:0] W_REP6  = {S_H, S_E, S_L, S_L, S_O, S_B, S_H, S_E};
    localparam logic [55:0] W_REP6W = {S_H, S_E, S_L, S_L, S_O, S_O, S_H, S_E};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0, dir = 1'b0, step = 1'b0, blink = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0, wr_data = '0;
    logic        wr_en2 = 1'b0;
    logic [2:0]  wr_addr2 = '0, wr_data2 = '0;
    logic [55:0] hex, hex2;
    logic [2:0]  offset, offset2;
    logic        tick, tick2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hex_scroller #(.NUM_DIGITS(8), .MSG_LEN(8), .CHAR_W(3), .TICK_DIV(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .dir     (dir),
        .step    (step),
`ifdef HEX_SCROLLER_BLINK_EN
        .blink   (blink),
`endif
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hex     (hex),
        .offset  (offset),
        .tick    (tick)
    );

    // Second instance: shorter message than the display, held still, used for wrap and range checks.
    hex_scroller #(.NUM_DIGITS(8), .MSG_LEN(6), .CHAR_W(3), .TICK_DIV(4)) u_dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (1'b0),
        .dir     (1'b0),
        .step    (1'b0),
`ifdef HEX_SCROLLER_BLINK_EN
        .blink   (1'b0),
`endif
        .wr_en   (wr_en2),
        .wr_addr (wr_addr2),
        .wr_data (wr_data2),
        .hex     (hex2),
        .offset  (offset2),
        .tick    (tick2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        check("tick_within_bound", 64'(seen), 64'd1);
    endtask

    function automatic logic [6:0] dig(input logic [55:0] h, input int k);
        return h[7*k +: 7];
    endfunction

    initial begin
        // Asynchronous reset, observed before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_hex",    64'(hex), {8'h0, {56{1'b1}}});
        check("rst_offset", 64'(offset), 64'd0);
        check("rst_tick",   64'(tick), 64'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("hello_window", 64'(hex), 64'(W_HELLO));
        check("hello_d7",     64'(dig(hex, 7)), 64'(S_H));
        check("hello_d0",     64'(dig(hex, 0)), 64'(S_B));
        check("hello_offset", 64'(offset), 64'd0);
        check("rep6_window",  64'(hex2), 64'(W_REP6));

        // Auto-scroll left.
        run = 1'b1;
        cyc(3);
        check("auto_off1",        64'(offset), 64'd1);
        check("hex_lag_one_cycle", 64'(hex), 64'(W_HELLO));
        cyc(1);
        check("off1_window", 64'(hex), 64'(W_OFF1));
        check("off1_d7",     64'(dig(hex, 7)), 64'(S_E));
        check("off1_d0",     64'(dig(hex, 0)), 64'(S_H));
        for (int i = 2; i <= 8; i++) begin
            cyc(4);
            check($sformatf("auto_off_%0d", i), 64'(offset), 64'(i % 8));
        end
        run = 1'b0;
        cyc(1);
        check("tick_low",  64'(tick), 64'd0);
        cyc(1);
        check("tick_high", 64'(tick), 64'd1);
        cyc(1);
        check("tick_ignored_run0", 64'(offset), 64'd0);

        // Manual step right wraps 0 -> 7; step is ignored while run=1.
        dir = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("step_right_wrap", 64'(offset), 64'd7);
        cyc(1);
        check("off7_window", 64'(hex), 64'(W_OFF7));
        run = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0; run = 1'b0;
        check("step_ignored_run1", 64'(offset), 64'd7);
        dir = 1'b0; step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("step_left_wrap", 64'(offset), 64'd0);

        // Write coincident with an auto advance.
        wait_tick();
        run = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 3'b011;
        cyc(1);
        run = 1'b0; wr_en = 1'b0;
        check("wr_adv_offset", 64'(offset), 64'd1);
        cyc(1);
        check("wr_adv_d3",     64'(dig(hex, 3)), 64'(S_O));
        check("wr_adv_window", 64'(hex), 64'(W_WR1));

        // Out-of-range writes on the 6-entry instance are dropped; an in-range one lands.
        wr_en2 = 1'b1; wr_addr2 = 3'd6; wr_data2 = 3'b000;
        cyc(1);
        wr_addr2 = 3'd7;
        cyc(1);
        wr_en2 = 1'b0;
        cyc(1);
        check("oor_write_ignored", 64'(hex2), 64'(W_REP6));
        wr_en2 = 1'b1; wr_addr2 = 3'd5; wr_data2 = 3'b011;
        cyc(1);
        wr_en2 = 1'b0;
        cyc(1);
        check("inrange_write", 64'(hex2), 64'(W_REP6W));

        // Reset in the middle of scrolling.
        step = 1'b1;
        cyc(4);
        step = 1'b0;
        check("pre_reset_offset", 64'(offset), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hex",    64'(hex), {8'h0, {56{1'b1}}});
        check("midrst_offset", 64'(offset), 64'd0);
        check("midrst_tick",   64'(tick), 64'd0);
        cyc(1);
        rst_n = 1'b1;
        blink = 1'b1;
        cyc(1);
        check("post_rst_hello",  64'(hex), 64'(W_HELLO));
        check("post_rst_rep6",   64'(hex2), 64'(W_REP6));
        check("post_rst_offset", 64'(offset), 64'd0);

`ifdef HEX_SCROLLER_BLINK_EN
        wait_tick();
        cyc(2);
        check("blink_off",        64'(hex), {8'h0, {56{1'b1}}});
        check("blink_offset_off", 64'(offset), 64'd0);
        wait_tick();
        cyc(2);
        check("blink_on",         64'(hex), 64'(W_HELLO));
        check("blink_offset_on",  64'(offset), 64'd0);
`else
        // Without the blink build the blink signal has no effect across ticks.
        wait_tick();
        cyc(2);
        check("no_blink_hex", 64'(hex), 64'(W_HELLO));
`endif
        blink = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
